// File: rtl/eth_prbs31_pkg.sv
// Shared PRBS31 checker definitions: polynomial taps, block/history
// widths, FSM state encoding and a 66-bit popcount helper.
package eth_prbs31_pkg;

   localparam int PRBS_TAP_A = 31;
   localparam int PRBS_TAP_B = 28;
   localparam int BLK_W      = 66;
   localparam int HIST_W     = PRBS_TAP_A;

   typedef enum logic [1:0] {
      PRIME,
      HUNT,
      LOCKED
   } prbs_state_t;

   function automatic logic [6:0] popcount66(
      input logic [BLK_W-1:0] v
   );
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < BLK_W; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_prbs31_err_calc.sv
// Combinational PRBS31 error vector and next history for one 66-bit block.
// Ports: h (31-bit history, h[30] newest), w (block bits, w[0] oldest),
//        e (per-bit error), h_next (history after this block).
module eth_prbs31_err_calc
   import eth_prbs31_pkg::*;
(
   input  logic [HIST_W-1:0] h,
   input  logic [BLK_W-1:0]  w,
   output logic [BLK_W-1:0]  e,
   output logic [HIST_W-1:0] h_next
);

   localparam int TAP_D = PRBS_TAP_A - PRBS_TAP_B;

   // s[0..30] = history, s[31..96] = this block, oldest first
   logic [HIST_W+BLK_W-1:0] s;

   assign s = {w, h};

   // each bit must equal the bits 31 and 28 positions earlier
   assign e = s[PRBS_TAP_A +: BLK_W]
            ^ s[0 +: BLK_W]
            ^ s[TAP_D +: BLK_W];

   assign h_next = s[BLK_W +: HIST_W];

endmodule

// File: rtl/eth_prbs31_checker.sv
// Receive-side PRBS31 checker: self-syncs to the 66-bit block stream,
// reports per-block bit errors, pattern lock and a saturating error total.
// Ports: rx_clk/rx_rst_n, cfg_rx_prbs31_enable, serdes_rx_{data,hdr,valid},
//        err_clear; outputs prbs_word_err_{count,valid}, prbs_locked,
//        prbs_err_total, prbs_err_sat.
module eth_prbs31_checker
   import eth_prbs31_pkg::*;
#(
   parameter int LOCK_WORDS   = 16,
   parameter int UNLOCK_WORDS = 4,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst_n,
   input  logic                 cfg_rx_prbs31_enable,
   input  logic [63:0]          serdes_rx_data,
   input  logic [1:0]           serdes_rx_hdr,
   input  logic                 serdes_rx_valid,
   input  logic                 err_clear,
   output logic [6:0]           prbs_word_err_count,
   output logic                 prbs_word_err_valid,
   output logic                 prbs_locked,
   output logic [CNT_WIDTH-1:0] prbs_err_total,
   output logic                 prbs_err_sat
);

   localparam int LW = $clog2(LOCK_WORDS + 1);
   localparam int UW = $clog2(UNLOCK_WORDS + 1);
   localparam int SW = CNT_WIDTH + 8;

   logic               en;
   logic               accept;
   logic [BLK_W-1:0]   w;
   logic [HIST_W-1:0]  h_q;
   logic [HIST_W-1:0]  h_next;
   logic [BLK_W-1:0]   e_d;
   logic [BLK_W-1:0]   e_q;
   logic               zero_q;
   logic               chk_q;
   logic               do_chk;
   prbs_state_t        state_q;
   prbs_state_t        state_d;
   logic [LW-1:0]      clean_q;
   logic [LW-1:0]      clean_d;
   logic [UW-1:0]      bad_q;
   logic [UW-1:0]      bad_d;
   logic [6:0]         blk_cnt;
   logic               blk_bad;
   logic [SW-1:0]      sum;
   logic [CNT_WIDTH-1:0] total_d;

   assign en     = cfg_rx_prbs31_enable;
   assign accept = en & serdes_rx_valid;
   assign w      = {serdes_rx_data, serdes_rx_hdr};
   assign do_chk = en & chk_q;

   eth_prbs31_err_calc u_err_calc (
      .h      (h_q),
      .w      (w),
      .e      (e_d),
      .h_next (h_next)
   );

   // stage 1: history, error vector, all-zero flag
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         h_q    <= '0;
         e_q    <= '0;
         zero_q <= 1'b0;
         chk_q  <= 1'b0;
      end else begin
         chk_q <= accept && (state_q != PRIME);
         if (accept) begin
            h_q    <= h_next;
            e_q    <= e_d;
            zero_q <= (w == '0);
         end
      end
   end

   // lock FSM; an all-zero block is never clean
   always_comb begin
      state_d = state_q;
      clean_d = clean_q;
      bad_d   = bad_q;
      blk_cnt = popcount66(e_q);
      blk_bad = (blk_cnt != 7'd0) | zero_q;
      if (!en) begin
         state_d = PRIME;
         clean_d = '0;
         bad_d   = '0;
      end else begin
         unique case (state_q)
            PRIME: begin
               if (accept) state_d = HUNT;
            end
            HUNT: begin
               if (chk_q) begin
                  if (blk_bad) begin
                     clean_d = '0;
                  end else if (clean_q == LW'(LOCK_WORDS - 1)) begin
                     state_d = LOCKED;
                     clean_d = '0;
                     bad_d   = '0;
                  end else begin
                     clean_d = clean_q + LW'(1);
                  end
               end
            end
            LOCKED: begin
               if (chk_q) begin
                  if (!blk_bad) begin
                     bad_d = '0;
                  end else if (bad_q == UW'(UNLOCK_WORDS - 1)) begin
                     state_d = HUNT;
                     clean_d = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + UW'(1);
                  end
               end
            end
            default: state_d = PRIME;
         endcase
      end
   end

   // accumulate only blocks checked while locked; clear wins
   always_comb begin
      sum     = SW'(prbs_err_total) + SW'(blk_cnt);
      total_d = prbs_err_total;
      if (err_clear) begin
         total_d = '0;
      end else if (do_chk && state_q == LOCKED) begin
         if (sum > SW'({CNT_WIDTH{1'b1}})) total_d = '1;
         else total_d = sum[CNT_WIDTH-1:0];
      end
   end

   // stage 2: results, FSM and accumulator
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q             <= PRIME;
         clean_q             <= '0;
         bad_q               <= '0;
         prbs_word_err_count <= '0;
         prbs_word_err_valid <= 1'b0;
         prbs_err_total      <= '0;
         prbs_err_sat        <= 1'b0;
      end else begin
         state_q             <= state_d;
         clean_q             <= clean_d;
         bad_q               <= bad_d;
         prbs_word_err_valid <= do_chk;
         if (do_chk) prbs_word_err_count <= blk_cnt;
         prbs_err_total      <= total_d;
         prbs_err_sat        <= &total_d;
      end
   end

   assign prbs_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_eth_prbs31_checker.sv
// Self-checking bench for eth_prbs31_checker: default instance plus a
// 4-bit accumulator instance sharing the same stimulus.
module tb_eth_prbs31_checker;

   logic        rx_clk = 1'b0;
   logic        rx_rst_n = 1'b0;
   logic        en = 1'b0;
   logic        vld = 1'b0;
   logic        clr = 1'b0;
   logic [63:0] data = '0;
   logic [1:0]  hdr = '0;

   logic [6:0]  cnt_a, cnt_b;
   logic        v_a, v_b, lk_a, lk_b, sat_a, sat_b;
   logic [31:0] tot_a;
   logic [3:0]  tot_b;

   int checks = 0;
   int failures = 0;

   localparam longint MAXA = 64'hFFFF_FFFF;
   localparam longint MAXB = 15;

   always #5 rx_clk = ~rx_clk;

   eth_prbs31_checker dut_a (
      .rx_clk               (rx_clk),
      .rx_rst_n             (rx_rst_n),
      .cfg_rx_prbs31_enable (en),
      .serdes_rx_data       (data),
      .serdes_rx_hdr        (hdr),
      .serdes_rx_valid      (vld),
      .err_clear            (clr),
      .prbs_word_err_count  (cnt_a),
      .prbs_word_err_valid  (v_a),
      .prbs_locked          (lk_a),
      .prbs_err_total       (tot_a),
      .prbs_err_sat         (sat_a)
   );

   eth_prbs31_checker #(.CNT_WIDTH(4)) dut_b (
      .rx_clk               (rx_clk),
      .rx_rst_n             (rx_rst_n),
      .cfg_rx_prbs31_enable (en),
      .serdes_rx_data       (data),
      .serdes_rx_hdr        (hdr),
      .serdes_rx_valid      (vld),
      .err_clear            (clr),
      .prbs_word_err_count  (cnt_b),
      .prbs_word_err_valid  (v_b),
      .prbs_locked          (lk_b),
      .prbs_err_total       (tot_b),
      .prbs_err_sat         (sat_b)
   );

   // reference model: bit-serial recurrence over the accepted stream
   bit     mq[$];
   bit     gen[$];
   int     m_state;
   int     m_clean;
   int     m_bad;
   bit     p_chk;
   int     p_cnt;
   bit     p_zero;
   int     e_cnt;
   bit     e_vld;
   longint e_tot;
   longint e_tot4;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      repeat (31) mq.push_back(1'b0);
      m_state = 0;
      m_clean = 0;
      m_bad   = 0;
      p_chk   = 0;
      p_cnt   = 0;
      p_zero  = 0;
      e_cnt   = 0;
      e_vld   = 0;
      e_tot   = 0;
      e_tot4  = 0;
   endtask

   function automatic logic [65:0] next_blk();
      logic [65:0] w;
      bit b;
      for (int k = 0; k < 66; k++) begin
         b = gen[0] ^ gen[3];
         gen.push_back(b);
         void'(gen.pop_front());
         w[k] = b;
      end
      return w;
   endfunction

   function automatic logic [65:0] flip(input logic [65:0] w,
                                        input int j);
      logic [65:0] r;
      r = w;
      r[j] = ~r[j];
      return r;
   endfunction

   task automatic model_edge(input bit e_i, input bit v_i,
                             input logic [65:0] w, input bit c_i);
      bit bad;
      bit nchk;
      int errs;
      bit x;
      e_vld = 0;
      if (e_i && p_chk) begin
         e_vld = 1;
         e_cnt = p_cnt;
         bad = (p_cnt != 0) || p_zero;
         if (m_state == 2) begin
            e_tot  = (e_tot + p_cnt > MAXA) ? MAXA : e_tot + p_cnt;
            e_tot4 = (e_tot4 + p_cnt > MAXB) ? MAXB : e_tot4 + p_cnt;
            m_bad = bad ? m_bad + 1 : 0;
            if (m_bad == 4) begin
               m_state = 1;
               m_clean = 0;
               m_bad = 0;
            end
         end else begin
            m_clean = bad ? 0 : m_clean + 1;
            if (m_clean == 16) begin
               m_state = 2;
               m_clean = 0;
               m_bad = 0;
            end
         end
      end
      if (c_i) begin
         e_tot = 0;
         e_tot4 = 0;
      end
      nchk = 0;
      if (!e_i) begin
         m_state = 0;
         m_clean = 0;
         m_bad = 0;
      end else if (v_i) begin
         errs = 0;
         for (int k = 0; k < 66; k++) begin
            x = mq[0] ^ mq[3];
            if (w[k] != x) errs++;
            mq.push_back(w[k]);
            void'(mq.pop_front());
         end
         if (m_state == 0) m_state = 1;
         else nchk = 1;
         p_cnt  = errs;
         p_zero = (w == '0);
      end
      p_chk = nchk;
   endtask

   task automatic compare_all();
      chk("valid_a", v_a, e_vld);
      chk("valid_b", v_b, e_vld);
      chk("count_a", cnt_a, e_cnt);
      chk("count_b", cnt_b, e_cnt);
      chk("locked_a", lk_a, m_state == 2);
      chk("locked_b", lk_b, m_state == 2);
      chk("total_a", tot_a, e_tot);
      chk("total_b", tot_b, e_tot4);
      chk("sat_a", sat_a, e_tot == MAXA);
      chk("sat_b", sat_b, e_tot4 == MAXB);
   endtask

   task automatic step(input bit e_i, input bit v_i,
                       input logic [65:0] w, input bit c_i);
      en   = e_i;
      vld  = v_i;
      data = w[65:2];
      hdr  = w[1:0];
      clr  = c_i;
      model_edge(e_i, v_i, w, c_i);
      @(posedge rx_clk);
      #1;
      compare_all();
   endtask

   task automatic relock();
      for (int i = 0; i < 20; i++) step(1, 1, next_blk(), 0);
      chk("relock", lk_a, 1);
   endtask

   typedef struct {
      bit en;
      bit vld;
      bit x_vld;
      int x_cnt;
      bit x_lock;
      int x_tot;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [65:0] w;
      bit any_lock;
      int nacc;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};

      gen.delete();
      repeat (31) gen.push_back(1'b1);
      model_reset();

      repeat (3) @(posedge rx_clk);
      #1;
      chk("reset_total", tot_a, 0);
      chk("reset_valid", v_a, 0);
      rx_rst_n = 1'b1;
      compare_all();

      // table: priming, first strobes, gap in valid
      nacc = 0;
      for (int i = 0; i < 8; i++) begin
         w = tbl[i].vld ? next_blk() : 66'd0;
         if (tbl[i].vld) nacc++;
         step(tbl[i].en, tbl[i].vld, w, 0);
         chk($sformatf("tbl%0d_vld", i), v_a, tbl[i].x_vld);
         chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].x_cnt);
         chk($sformatf("tbl%0d_lock", i), lk_a, tbl[i].x_lock);
         chk($sformatf("tbl%0d_tot", i), tot_a, tbl[i].x_tot);
      end

      // lock rises one edge after the 17th accepted block
      for (int b = nacc + 1; b <= 18; b++) begin
         step(1, 1, next_blk(), 0);
         if (b == 17) chk("pre_lock", lk_a, 0);
         if (b == 18) chk("lock_rise", lk_a, 1);
      end
      chk("lock_total", tot_a, 0);

      // single flip of data[10] -> 3 errors
      step(1, 1, flip(next_blk(), 12), 0);
      step(1, 1, next_blk(), 0);
      chk("flip_cnt", cnt_a, 3);
      chk("flip_tot", tot_a, 3);
      chk("flip_lock", lk_a, 1);

      // 3 heavily errored blocks then clean: lock held, 4-bit total sats
      step(1, 1, flip(flip(flip(next_blk(), 0), 1), 2), 0);
      step(1, 1, flip(flip(flip(next_blk(), 0), 1), 2), 0);
      chk("nine_cnt", cnt_a, 9);
      chk("tot_b_12", tot_b, 12);
      chk("sat_b_0", sat_b, 0);
      step(1, 1, flip(flip(flip(next_blk(), 0), 1), 2), 0);
      step(1, 1, next_blk(), 0);
      chk("tot_a_30", tot_a, 30);
      chk("tot_b_sat", tot_b, 15);
      chk("sat_b_1", sat_b, 1);
      step(1, 1, next_blk(), 0);
      chk("held_lock", lk_a, 1);

      // err_clear in the same cycle as an errored strobe
      step(1, 1, flip(next_blk(), 12), 0);
      step(1, 1, next_blk(), 1);
      chk("clr_cnt", cnt_a, 3);
      chk("clr_tot_a", tot_a, 0);
      chk("clr_tot_b", tot_b, 0);
      step(1, 1, next_blk(), 0);
      chk("clr_sat_b", sat_b, 0);

      // 4 errored blocks drop lock with the 4th strobe
      for (int i = 0; i < 4; i++) step(1, 1, flip(next_blk(), 5), 0);
      chk("unlock_pre", lk_a, 1);
      step(1, 1, next_blk(), 0);
      chk("unlock", lk_a, 0);
      chk("unlock_tot", tot_a, 12);

      // all-zero blocks while locked
      relock();
      for (int i = 0; i < 4; i++) step(1, 1, 66'd0, 0);
      chk("zero_pre", lk_a, 1);
      step(1, 1, 66'd0, 0);
      chk("zero_unlock", lk_a, 0);
      any_lock = 0;
      for (int i = 0; i < 100; i++) begin
         step(1, 1, 66'd0, 0);
         any_lock |= lk_a;
      end
      chk("zero_nolock", any_lock, 0);
      chk("zero_cnt", cnt_a, 0);

      // asynchronous reset while locked
      relock();
      step(1, 1, flip(next_blk(), 20), 0);
      step(1, 1, next_blk(), 0);
      chk("pre_rst_tot", tot_a, e_tot);
      en  = 0;
      vld = 0;
      #2;
      rx_rst_n = 1'b0;
      #1;
      chk("rst_lock", lk_a, 0);
      chk("rst_tot", tot_a, 0);
      chk("rst_vld", v_a, 0);
      model_reset();
      @(posedge rx_clk);
      #1;
      rx_rst_n = 1'b1;
      compare_all();

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bit re, rv, rc;
         re = ($urandom_range(0, 79) != 0);
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 59) == 0);
         w = 66'd0;
         if (rv) begin
            w = next_blk();
            if ($urandom_range(0, 7) == 0)
               w = flip(w, $urandom_range(0, 65));
            if ($urandom_range(0, 40) == 0) w = 66'd0;
         end
         step(re, rv, w, rc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_prbs31_checker.md
# eth_prbs31_checker

Receive-side PRBS31 (x^31 + x^28 + 1) pattern checker for the 10GBASE-R PHY test mode. It sits on the SerDes receive path, in parallel with the 64b/66b decoder, and consumes the raw 66-bit block stream (header plus data). It self-synchronizes to the incoming pattern, reports per-block bit-error counts, maintains a pattern-lock flag, and accumulates a saturating total error count. It is the checking end for the PRBS31 pattern produced by the transmit-side generator.

## Interface
- LOCK_WORDS, 16, consecutive clean checked blocks required to declare lock
- UNLOCK_WORDS, 4, consecutive errored checked blocks that drop lock
- CNT_WIDTH, 32, width of the total error accumulator
- rx_clk  in  1  receive clock; all logic is on its rising edge
- rx_rst_n  in  1  reset, asynchronous, active-low
- cfg_rx_prbs31_enable  in  1  checker enable
- serdes_rx_data  in  64  block payload
- serdes_rx_hdr  in  2  block sync header
- serdes_rx_valid  in  1  block qualifier
- err_clear  in  1  synchronous clear of prbs_err_total
- prbs_word_err_count  out  7  mismatched bits in the last checked block (0..66)
- prbs_word_err_valid  out  1  one-cycle strobe qualifying prbs_word_err_count
- prbs_locked  out  1  pattern lock
- prbs_err_total  out  CNT_WIDTH  saturating error sum, accumulated while locked
- prbs_err_sat  out  1  high while prbs_err_total is all ones

## Operation
- Bit stream order per block: w[0]=hdr[0], w[1]=hdr[1], w[2+i]=data[i], i=0..63. w[0] is the oldest bit.
- 31-bit history h, with h[30] being the most recent bit. Define s[0..30]=h and s[31+k]=w[k]. Error bit: e[k] = s[31+k] ^ s[k] ^ s[k+3], k=0..65.
- On every accepted block (valid and enable), h is loaded with w[65:35], in every state.
- FSM states:
  - PRIME: the first accepted block only loads h. It produces no strobe and then goes to HUNT.
  - HUNT: a checked block with zero errors whose 66 bits are not all zero increments the clean counter. Any other block clears the counter. When the counter reaches LOCK_WORDS, go to LOCKED.
  - LOCKED: a block is errored if its error count is nonzero or its 66 bits are all zero. Errored blocks increment the bad counter and clean blocks clear it. When the counter reaches UNLOCK_WORDS, go to HUNT with the clean counter set to 0.
- The all-zero rule exists because the all-zero sequence satisfies the recurrence and must never produce or hold lock.
- prbs_err_total adds the block error count only for blocks checked while in LOCKED, including the block that causes unlock. The sum saturates at 2^CNT_WIDTH-1.
- err_clear has priority: it zeroes the total, and any increment in that same cycle is discarded.
- cfg_rx_prbs31_enable low:
  - FSM returns to PRIME, counters are cleared, and prbs_locked goes to 0.
  - Pipeline valid bits are cleared.
  - prbs_err_total holds its value, and err_clear still works.
- Reset values: every output is 0, h=0, FSM in PRIME.

## Timing
- Two-stage pipeline:
  - Stage 1 (edge N, block sampled): registers e[65:0], an all-zero flag and a check-valid bit.
  - Stage 2 (edge N+1): registers prbs_word_err_count as the popcount of e and pulses prbs_word_err_valid for one cycle. It also updates the FSM, prbs_locked, prbs_err_total and prbs_err_sat.
- Latency from block to results is 2 edges. Throughput is one block per cycle, and gaps in valid are allowed without loss of history.
- A single flipped bit at stream index j produces errors at j, j+28 and j+31, so the effect can spill into the next block.
- Reset assertion at any time clears state immediately. There is no recovery of in-flight blocks.

## Structure
- Shared package: PRBS31 tap constants (31, 28), block width 66, and an FSM state enum {PRIME, HUNT, LOCKED}.
- One sub-module is natural: eth_prbs31_err_calc, a combinational error-vector and history-next function of (h, w). It is reused by the transmit-side generator's self-test.
- Top level holds the pipeline registers, a 66-bit popcount, the FSM and the accumulator.

## Test plan
- Reset released, no input -> all outputs 0. Assert rx_rst_n low mid-lock -> prbs_locked=0 and prbs_err_total=0 on the same cycle.
- Clean PRBS31 stream (seed 31'h7FFFFFFF), valid every cycle -> first block has no strobe. Counts are 0 on all later blocks. prbs_locked rises 2 edges after the 17th accepted block. Total stays 0.
- While locked, flip data[10] (stream index 12) -> that block reports prbs_word_err_count=3, total=3, lock is held.
- Constant all-zero blocks for 100 cycles -> every count is 0 and prbs_locked never asserts. The same input while locked -> lock drops after 4 blocks.
- Locked, 3 corrupted blocks then clean -> lock held. 4 corrupted blocks -> prbs_locked falls with the 4th strobe.
- CNT_WIDTH=4, inject errors summing past 15 -> total=15 and prbs_err_sat=1. err_clear in the same cycle as an errored strobe -> total=0.
